// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier issue controller.
package mul_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned TREE_STAGES = 8;
  // One extra stage for the final carry-propagate adder.
  localparam int unsigned LAT_DFLT    = TREE_STAGES + 1;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  function automatic logic op_sign_a(input mul_op_t op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_sign_b(input mul_op_t op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_resp_fifo.sv
// Synchronous result FIFO; head is visible combinationally, push+pop allowed when full.
module mul_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage is data-only; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Credit-gated issue controller for the fixed-latency multiplier datapath,
// with operand extension, result-half selection and a local result buffer.
module mul_issue_ctrl #(
  parameter int unsigned XLEN       = mul_pkg::XLEN,
  parameter int unsigned LAT        = mul_pkg::LAT_DFLT,
  parameter int unsigned OBUF_DEPTH = 4,
  parameter int unsigned TAG_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              dp_issue,
  output logic [XLEN:0]     dp_a,
  output logic [XLEN:0]     dp_b,
  input  logic [2*XLEN-1:0] dp_prod,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              busy
);

  import mul_pkg::*;

  localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned FW = XLEN + TAG_W;

  logic [CW-1:0]             r_cnt;
  logic [LAT-1:0]            r_vld;
  logic [LAT-1:0][1:0]       r_op;
  logic [LAT-1:0][TAG_W-1:0] r_tag;

  mul_op_t         w_req_op;
  logic            w_issue;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [XLEN-1:0] w_res;
  logic [FW-1:0]   w_rdata;

  assign w_req_op  = mul_op_t'(req_op);
  assign req_ready = (r_cnt < CW'(OBUF_DEPTH)) && !flush;
  assign w_issue   = req_valid && req_ready;
  assign dp_issue  = w_issue;
  assign dp_a      = {op_sign_a(w_req_op) & req_a[XLEN-1], req_a};
  assign dp_b      = {op_sign_b(w_req_op) & req_b[XLEN-1], req_b};

  assign resp_valid = !w_empty;
  assign w_pop      = resp_valid && resp_ready && !flush;
  assign busy       = (r_cnt != '0);

  // Credits cover in-flight plus buffered ops, so the buffer can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (flush) r_cnt <= '0;
    else            r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);
  end

  if (LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vld <= '0;
      else        r_vld <= w_issue;
    end

    always_ff @(posedge clk) begin
      r_op  <= req_op;
      r_tag <= req_tag;
    end
  end else begin : g_latn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_vld <= '0;
      else if (flush) r_vld <= '0;
      else            r_vld <= {r_vld[LAT-2:0], w_issue};
    end

    // Op/tag ride alongside vld; only vld needs reset since it gates capture.
    always_ff @(posedge clk) begin
      r_op  <= {r_op[LAT-2:0], req_op};
      r_tag <= {r_tag[LAT-2:0], req_tag};
    end
  end

  assign w_res  = (mul_op_t'(r_op[LAT-1]) == MUL_OP_MUL) ? dp_prod[XLEN-1:0]
                                                         : dp_prod[2*XLEN-1:XLEN];
  assign w_push = r_vld[LAT-1] && !flush && (!w_full || w_pop);

  mul_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (OBUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (w_push),
    .wdata ({w_res, r_tag[LAT-1]}),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign resp_data = w_rdata[FW-1:TAG_W];
  assign resp_tag  = w_rdata[TAG_W-1:0];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: behavioural datapath plus an
// in-order result queue computed from RV64 multiply semantics.
module tb_mul_issue_ctrl;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned LAT   = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [TAG_W-1:0]  req_tag;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;
  logic              flush;
  logic              dp_issue;
  logic [XLEN:0]     dp_a;
  logic [XLEN:0]     dp_b;
  logic [2*XLEN-1:0] dp_prod;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              busy;

  mul_issue_ctrl #(
    .XLEN(XLEN), .LAT(LAT), .OBUF_DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_a(req_a), .req_b(req_b), .flush(flush),
    .dp_issue(dp_issue), .dp_a(dp_a), .dp_b(dp_b), .dp_prod(dp_prod),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Datapath model: (XLEN+1)x(XLEN+1) signed multiply, LAT cycles later; junk otherwise.
  logic [2*XLEN-1:0] pipe [LAT];

  function automatic logic [2*XLEN-1:0] dp_model(input logic [XLEN:0] a, input logic [XLEN:0] b);
    logic [2*XLEN+1:0] ea;
    logic [2*XLEN+1:0] eb;
    logic [2*XLEN+1:0] p;
    ea = {{(XLEN+1){a[XLEN]}}, a};
    eb = {{(XLEN+1){b[XLEN]}}, b};
    p  = ea * eb;
    return p[2*XLEN-1:0];
  endfunction

  always @(posedge clk) begin
    pipe[0] <= dp_issue ? dp_model(dp_a, dp_b)
                        : {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_prod = pipe[LAT-1];

  // Buffer must never be pushed while full unless a pop frees a slot.
  always @(negedge clk) begin
    if (rst_n && dut.w_push) begin
      checks++;
      if (dut.w_full && !dut.w_pop) begin
        errors++;
        $display("FAIL overflow: push while full without pop at cycle %0d", cyc);
      end
    end
  end

  // Architectural result of an RV64 M-extension multiply.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] p;
    ea = (op == 2'd3)  ? {64'd0, a} : {{64{a[63]}}, a};
    eb = (op >= 2'd2)  ? {64'd0, b} : {{64{b[63]}}, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'd1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  typedef struct packed {
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
  } exp_t;
  exp_t mq[$];

  logic             s_rdy, s_valid, s_busy, s_dpi, s_acc, s_pop, e_has;
  logic [XLEN:0]    s_dpa, s_dpb;
  logic [63:0]      s_data, e_data;
  logic [TAG_W-1:0] s_tag, e_tag;
  int               s_mcnt;

  // One clock: drive, sample mid-cycle, update the reference queue, advance.
  task automatic tick(input logic v, input logic [1:0] op, input logic [TAG_W-1:0] tg,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic rr, input logic fl);
    req_valid = v; req_op = op; req_tag = tg; req_a = a; req_b = b;
    resp_ready = rr; flush = fl;
    #1;
    s_rdy = req_ready; s_valid = resp_valid; s_busy = busy; s_dpi = dp_issue;
    s_dpa = dp_a; s_dpb = dp_b; s_data = resp_data; s_tag = resp_tag;
    s_mcnt = mq.size();
    s_acc = v && s_rdy;
    s_pop = s_valid && rr && !fl;
    e_has = 1'b0;
    if (s_pop && mq.size() != 0) begin
      e_has = 1'b1; e_data = mq[0].d; e_tag = mq[0].t;
      void'(mq.pop_front());
    end
    if (s_acc) mq.push_back('{d: ref_mul(op, a, b), t: tg});
    if (fl) mq.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 2'd0, '0, 64'd0, 64'd0, rr, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_tag = '0;
    req_a = '0; req_b = '0; flush = 1'b0; resp_ready = 1'b0;
    #3;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || dp_issue !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: resp_valid=%b busy=%b dp_issue=%b want 0/0/0", resp_valid, busy, dp_issue);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [XLEN:0] ea;
    logic [XLEN:0] eb;
    int n;
    ea = {1'b0, 64'd3};
    eb = {1'b1, 64'hFFFF_FFFF_FFFF_FFFB};
    tick(1'b1, 2'd0, 5'd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0);
    checks++;
    if (s_acc !== 1'b1 || s_dpi !== 1'b1 || s_dpa !== ea || s_dpb !== eb) begin
      errors++;
      $display("FAIL mul_issue: acc=%b dpi=%b dp_a=%h dp_b=%h want 1 1 %h %h", s_acc, s_dpi, s_dpa, s_dpb, ea, eb);
    end
    n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      idle(1'b1);
      if (s_valid) n = i;
    end
    checks++;
    if (n != LAT + 1) begin
      errors++; $display("FAIL mul_latency: got %0d cycles want %0d", n, LAT + 1);
    end
    checks++;
    if (s_data !== 64'hFFFF_FFFF_FFFF_FFF1 || s_tag !== 5'd7 || !e_has || s_data !== e_data) begin
      errors++;
      $display("FAIL mul_result: data=%h tag=%0d want FFFFFFFFFFFFFFF1 tag 7", s_data, s_tag);
    end
    idle(1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL mul_drain: valid=%b busy=%b want 0 0", s_valid, s_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ex [3];
    logic [63:0] gd [3];
    logic [4:0]  gt [3];
    int          gc [3];
    int          k;
    ex = '{64'd2, '1, '1};
    tick(1'b1, 2'd3, 5'd10, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0);
    checks++;
    if (s_dpa[XLEN] !== 1'b0 || s_dpb[XLEN] !== 1'b0) begin
      errors++; $display("FAIL mulhu_ext: a_msb=%b b_msb=%b want 0 0", s_dpa[XLEN], s_dpb[XLEN]);
    end
    tick(1'b1, 2'd1, 5'd11, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0);
    checks++;
    if (s_dpb[XLEN] !== 1'b1) begin
      errors++; $display("FAIL mulh_ext: b_msb=%b want 1", s_dpb[XLEN]);
    end
    tick(1'b1, 2'd2, 5'd12, '1, 64'd2, 1'b1, 1'b0);
    checks++;
    if (s_dpa[XLEN] !== 1'b1 || s_dpb[XLEN] !== 1'b0) begin
      errors++; $display("FAIL mulhsu_ext: a_msb=%b b_msb=%b want 1 0", s_dpa[XLEN], s_dpb[XLEN]);
    end
    k = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1'b1);
      if (s_pop && k < 3) begin
        gd[k] = s_data; gt[k] = s_tag; gc[k] = cyc; k++;
      end
    end
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL b2b_count: got %0d results want 3", k);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (gd[j] !== ex[j] || gt[j] !== 5'(10 + j) || gc[j] != gc[0] + j) begin
          errors++;
          $display("FAIL b2b_res%0d: data=%h tag=%0d cyc=%0d want %h tag %0d cyc %0d",
                   j, gd[j], gt[j], gc[j], ex[j], 10 + j, gc[0] + j);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int at;
    int pops;
    int first;
    logic [63:0] hold;
    acc = 0; at = 99;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 2'($urandom_range(0, 3)), 5'(acc + 1), rnd64(), rnd64(), 1'b0, 1'b0);
      if (s_acc) begin
        acc++;
        if (acc == 4) at = i;
      end else if (i > at) begin
        checks++;
        if (s_rdy !== 1'b0 || s_busy !== 1'b1) begin
          errors++; $display("FAIL bp_full: ready=%b busy=%b want 0 1", s_rdy, s_busy);
        end
      end
    end
    checks++;
    if (acc != 4 || at != 3) begin
      errors++; $display("FAIL bp_accepts: got %0d (4th at %0d) want 4 (at 3)", acc, at);
    end
    for (int i = 0; i < int'(LAT); i++) idle(1'b0);
    hold = s_data;
    idle(1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_tag !== 5'd1 || s_data !== hold) begin
      errors++; $display("FAIL bp_hold: valid=%b tag=%0d data=%h want 1 tag 1 %h", s_valid, s_tag, s_data, hold);
    end
    pops = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (i == first + 1 && first >= 0) begin
        checks++;
        if (s_rdy !== 1'b1) begin
          errors++; $display("FAIL bp_ready_ret: ready=%b want 1", s_rdy);
        end
      end
      if (s_pop) begin
        if (first < 0) begin
          first = i;
          checks++;
          if (s_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_ready_pop: ready=%b want 0", s_rdy);
          end
        end
        pops++;
        checks++;
        if (!e_has || s_data !== e_data || s_tag !== e_tag || s_tag !== 5'(pops)) begin
          errors++;
          $display("FAIL bp_order: data=%h tag=%0d want %h tag %0d", s_data, s_tag, e_data, pops);
        end
      end
    end
    checks++;
    if (pops != 4) begin
      errors++; $display("FAIL bp_pops: got %0d want 4", pops);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++)
      tick(1'b1, 2'($urandom_range(0, 3)), 5'(20 + i), rnd64(), rnd64(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (s_valid) seen++;
    end
    tick(1'b1, 2'd0, 5'd31, rnd64(), rnd64(), 1'b1, 1'b1);
    checks++;
    if (s_rdy !== 1'b0 || s_dpi !== 1'b0) begin
      errors++; $display("FAIL flush_ready: ready=%b dp_issue=%b want 0 0", s_rdy, s_dpi);
    end
    idle(1'b1);
    checks++;
    if (s_busy !== 1'b0 || s_rdy !== 1'b1) begin
      errors++; $display("FAIL flush_after: busy=%b ready=%b want 0 1", s_busy, s_rdy);
    end
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      idle(1'b1);
      if (s_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_kill: %0d stale resp_valid cycles want 0", seen);
    end
  endtask

  task automatic test_turnover();
    for (int i = 0; i < 4; i++)
      tick(1'b1, 2'($urandom_range(0, 3)), 5'(i), rnd64(), rnd64(), 1'b0, 1'b0);
    for (int i = 0; i < int'(LAT) + 2; i++) idle(1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 2'($urandom_range(0, 3)), 5'(i + 8), rnd64(), rnd64(), 1'b1, 1'b0);
      checks++;
      if (s_busy !== (s_mcnt != 0) || s_rdy !== (s_mcnt < int'(DEPTH))) begin
        errors++;
        $display("FAIL turn_credit: busy=%b ready=%b model_cnt=%0d", s_busy, s_rdy, s_mcnt);
      end
      if (s_pop) begin
        checks++;
        if (!e_has || s_data !== e_data || s_tag !== e_tag) begin
          errors++; $display("FAIL turn_data: data=%h tag=%0d want %h tag %0d", s_data, s_tag, e_data, e_tag);
        end
      end
    end
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      idle(1'b1);
      if (s_pop) begin
        checks++;
        if (!e_has || s_data !== e_data || s_tag !== e_tag) begin
          errors++; $display("FAIL turn_drain: data=%h tag=%0d want %h tag %0d", s_data, s_tag, e_data, e_tag);
        end
      end
    end
  endtask

  task automatic test_random();
    logic fl;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 49) == 0);
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           rnd64(), rnd64(), $urandom_range(0, 3) != 0, fl);
      checks++;
      if (s_rdy !== (s_mcnt < int'(DEPTH) && !fl) || s_busy !== (s_mcnt != 0)) begin
        errors++;
        $display("FAIL rnd_credit: ready=%b busy=%b model_cnt=%0d flush=%b", s_rdy, s_busy, s_mcnt, fl);
      end
      if (s_pop) begin
        checks++;
        if (!e_has || s_data !== e_data || s_tag !== e_tag) begin
          errors++; $display("FAIL rnd_data: data=%h tag=%0d want %h tag %0d", s_data, s_tag, e_data, e_tag);
        end
      end
    end
    tick(1'b0, 2'd0, '0, 64'd0, 64'd0, 1'b1, 1'b1);
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    tick(1'b1, 2'd0, 5'd1, rnd64(), rnd64(), 1'b0, 1'b0);
    tick(1'b1, 2'd1, 5'd2, rnd64(), rnd64(), 1'b0, 1'b0);
    for (int i = 0; i < int'(LAT) + 1; i++) idle(1'b0);
    tick(1'b1, 2'd2, 5'd3, rnd64(), rnd64(), 1'b0, 1'b0);
    tick(1'b1, 2'd3, 5'd4, rnd64(), rnd64(), 1'b0, 1'b0);
    idle(1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: valid=%b busy=%b want 1 1", s_valid, s_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: valid=%b busy=%b want 0 0", resp_valid, busy);
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      idle(1'b1);
      if (s_valid) seen++;
    end
    checks++;
    if (seen != 0 || s_busy !== 1'b0) begin
      errors++; $display("FAIL rst_stale: %0d stale valid cycles busy=%b want 0 0", seen, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_turnover();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
